// File: rtl/vga_scan_sched.sv
// VGA timing generator and test-pattern scheduler for the pixel datapath.
// Optional macro VGA_SCAN_BORDER_EN adds the registered border output.
module vga_scan_sched #(
  parameter int H_ACTIVE       = 640,
  parameter int H_FP           = 16,
  parameter int H_SYNC         = 96,
  parameter int H_BP           = 48,
  parameter int V_ACTIVE       = 480,
  parameter int V_FP           = 10,
  parameter int V_SYNC         = 2,
  parameter int V_BP           = 33,
  parameter int FRAMES_PER_PAT = 60
) (
  input  logic       vga_clk,
  input  logic       vga_rst,
  input  logic       en,
  input  logic       next_pat,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] x_pos,
  output logic [9:0] y_pos,
  output logic       frame_start,
  output logic [1:0] pat_sel
`ifdef VGA_SCAN_BORDER_EN
  ,
  output logic       border
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_BEG  = H_ACTIVE + H_FP;
  localparam int HS_END  = H_ACTIVE + H_FP + H_SYNC - 1;
  localparam int VS_BEG  = V_ACTIVE + V_FP;
  localparam int VS_END  = V_ACTIVE + V_FP + V_SYNC - 1;
  localparam int FW      =
    (FRAMES_PER_PAT > 1) ? $clog2(FRAMES_PER_PAT) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [9:0]    h_q, h_d;
  logic [9:0]    v_q, v_d;
  logic [FW-1:0] frame_q, frame_d;
  logic          pend_q, pend_d;
  logic [1:0]    pat_q, pat_d;

  logic          scan;
  logic          h_last;
  logic          v_last;
  logic          wrap;

  logic          von_d;
  logic          hs_d;
  logic          vs_d;
  logic          fs_d;

  assign scan   = (state_q != IDLE);
  assign h_last = (h_q == 10'(H_TOTAL - 1));
  assign v_last = (v_q == 10'(V_TOTAL - 1));
  assign wrap   = scan && h_last && v_last;

  // Scan FSM: a frame that has started always runs to its wrap.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (en) state_d = RUN;
      end
      RUN: begin
        if (!en) state_d = wrap ? IDLE : DRAIN;
      end
      DRAIN: begin
        if (en) state_d = RUN;
        else if (wrap) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Raster counters advance only while scanning, parked at 0 in IDLE.
  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (scan) begin
      if (h_last) begin
        h_d = '0;
        v_d = v_last ? '0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
    end
  end

  // Pattern scheduler: pat changes only at a frame wrap, by at most one.
  // A request seen on the wrap cycle itself is carried to the next wrap.
  always_comb begin
    frame_d = frame_q;
    pend_d  = pend_q | next_pat;
    pat_d   = pat_q;
    if (wrap) begin
      if (pend_q || frame_q == FW'(FRAMES_PER_PAT - 1)) begin
        pat_d   = pat_q + 2'd1;
        frame_d = '0;
      end else begin
        frame_d = frame_q + FW'(1);
      end
      pend_d = next_pat;
    end
  end

  // Decode of the current counter state, registered below.
  always_comb begin
    von_d = scan && (h_q < 10'(H_ACTIVE)) && (v_q < 10'(V_ACTIVE));
    hs_d  = !(scan && h_q >= 10'(HS_BEG) && h_q <= 10'(HS_END));
    vs_d  = !(scan && v_q >= 10'(VS_BEG) && v_q <= 10'(VS_END));
    fs_d  = scan && (h_q == 10'd0) && (v_q == 10'd0);
  end

  // Control and counter state registers.
  always_ff @(posedge vga_clk or posedge vga_rst) begin
    if (vga_rst) begin
      state_q <= IDLE;
      h_q     <= '0;
      v_q     <= '0;
      frame_q <= '0;
      pend_q  <= 1'b0;
      pat_q   <= '0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      v_q     <= v_d;
      frame_q <= frame_d;
      pend_q  <= pend_d;
      pat_q   <= pat_d;
    end
  end

  // Output registers; pat_sel moves together with frame_start.
  always_ff @(posedge vga_clk or posedge vga_rst) begin
    if (vga_rst) begin
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      video_on    <= 1'b0;
      x_pos       <= '0;
      y_pos       <= '0;
      frame_start <= 1'b0;
      pat_sel     <= '0;
    end else begin
      hsync       <= hs_d;
      vsync       <= vs_d;
      video_on    <= von_d;
      x_pos       <= von_d ? h_q : 10'd0;
      y_pos       <= von_d ? v_q : 10'd0;
      frame_start <= fs_d;
      pat_sel     <= pat_q;
    end
  end

`ifdef VGA_SCAN_BORDER_EN
  // Outline of the active window, aligned with video_on.
  always_ff @(posedge vga_clk or posedge vga_rst) begin
    if (vga_rst) begin
      border <= 1'b0;
    end else begin
      border <= von_d &&
                (h_q == 10'd0 || h_q == 10'(H_ACTIVE - 1) ||
                 v_q == 10'd0 || v_q == 10'(V_ACTIVE - 1));
    end
  end
`endif

endmodule
